// File: rtl/vga_line_prefetch_ctrl.sv
// Scanline prefetch scheduler for the VGA pixel pipeline.
// During the horizontal blank of line n it issues burst reads for line n+1
// into one half of a ping-pong line buffer while line n is shown from the
// other half. Pixels reach the colour path one clock after h_count/v_count.
// Ports:
//   vga_clk, rstn               pixel clock, async active-low reset
//   h_count, v_count            timing generator counters
//   enable                      fetch/display enable
//   fb_base                     framebuffer byte base (latched at frame trigger)
//   rd_req_valid/ready/addr/len read request channel (len in pixels)
//   rd_data_valid, rd_data      in-order read beats, one pixel each
//   pix_rgb, pix_valid          pixel output
//   underflow, underflow_clr    sticky underflow flag and its clear
//   busy                        fetch FSM not idle
module vga_line_prefetch_ctrl #(
  parameter int H_PIXELS  = 800,
  parameter int V_PIXELS  = 600,
  parameter int H_PERIOD  = 1040,
  parameter int V_PERIOD  = 666,
  parameter int BURST_LEN = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              vga_clk,
  input  logic              rstn,
  input  logic [11:0]       h_count,
  input  logic [11:0]       v_count,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [7:0]        rd_req_len,
  input  logic              rd_data_valid,
  input  logic [23:0]       rd_data,
  output logic [23:0]       pix_rgb,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              underflow_clr,
  output logic              busy
);

  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int MW = $clog2(2 * H_PIXELS);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t            state;
  logic              tgt_bank;
  logic [PW-1:0]     wr_ptr;
  logic [7:0]        beats_left;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        bank_ready;
  logic              show;
  logic              line_black;
  logic [23:0]       rd_q;
  logic [23:0]       mem [0:2*H_PIXELS-1];

  // Burst length for the next request given pixels already fetched.
  function automatic logic [7:0] burst_len(input logic [PW-1:0] done);
    int unsigned rem;
    rem = 32'(H_PIXELS) - 32'(done);
    return (rem > 32'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(rem);
  endfunction

  logic              trig_line, trig_frame, trig, trig_bank;
  logic [11:0]       trig_line_num;
  logic [ADDR_W-1:0] base_sel, line_addr;
  logic [PW-1:0]     wr_next;

  assign trig_line     = enable && (h_count == 12'(H_PIXELS)) && (v_count < 12'(V_PIXELS - 1));
  assign trig_frame    = enable && (h_count == 12'(H_PIXELS)) && (v_count == 12'(V_PERIOD - 1));
  assign trig          = trig_line || trig_frame;
  assign trig_line_num = trig_frame ? '0 : v_count + 12'd1;
  assign trig_bank     = trig_line_num[0];
  assign base_sel      = trig_frame ? fb_base : base_q;
  assign line_addr     = base_sel + ADDR_W'(trig_line_num) * ADDR_W'(H_PIXELS * 4);
  assign wr_next       = wr_ptr + PW'(1);

  assign rd_req_valid = (state == REQ);
  assign busy         = (state != IDLE);

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      tgt_bank    <= 1'b0;
      wr_ptr      <= '0;
      beats_left  <= '0;
      base_q      <= '0;
      bank_ready  <= '0;
      rd_req_addr <= '0;
      rd_req_len  <= '0;
    end else begin
      case (state)
        IDLE: if (trig) begin
          state       <= REQ;
          tgt_bank    <= trig_bank;
          wr_ptr      <= '0;
          rd_req_addr <= line_addr;
          rd_req_len  <= burst_len('0);
          if (trig_frame) base_q <= fb_base;
        end
        REQ: if (rd_req_ready) begin
          state      <= DATA;
          beats_left <= rd_req_len;
        end
        DATA: if (rd_data_valid) begin
          wr_ptr     <= wr_next;
          beats_left <= beats_left - 8'd1;
          if (beats_left == 8'd1) begin
            if (wr_next < PW'(H_PIXELS)) begin
              state       <= REQ;
              rd_req_addr <= rd_req_addr + ADDR_W'({rd_req_len, 2'b00});
              rd_req_len  <= burst_len(wr_next);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          bank_ready[tgt_bank] <= 1'b1;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A trigger (accepted or dropped) always invalidates its bank; placed
      // last so it overrides a same-cycle DONE set.
      if (trig) bank_ready[trig_bank] <= 1'b0;
    end
  end

  logic            active, starve, black;
  logic [MW-1:0]   widx, ridx;

  assign active = (h_count < 12'(H_PIXELS)) && (v_count < 12'(V_PIXELS));
  assign starve = enable && (h_count == 12'd0) && (v_count < 12'(V_PIXELS)) && !bank_ready[v_count[0]];
  // The line-start decision must also blank pixel 0 of the starved line.
  assign black  = (h_count == 12'd0) ? starve : line_black;
  assign widx   = tgt_bank   ? MW'(H_PIXELS) + MW'(wr_ptr)  : MW'(wr_ptr);
  assign ridx   = v_count[0] ? MW'(H_PIXELS) + MW'(h_count) : MW'(h_count);

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      show       <= 1'b0;
      line_black <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      show <= active && enable && bank_ready[v_count[0]] && !black;
      if (h_count == 12'd0) line_black <= starve;
      if (starve)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

  // Line buffer: one write port (fetch) and one read port (display).
  always_ff @(posedge vga_clk) begin
    if (state == DATA && rd_data_valid) mem[widx] <= rd_data;
    if (active) rd_q <= mem[ridx];
  end

  assign pix_rgb   = show ? rd_q : '0;
  assign pix_valid = show;

endmodule

// File: doc/vga_line_prefetch_ctrl.md
Name: vga_line_prefetch_ctrl

Overview:
- Scanline prefetch scheduler between the DDR read port and the 800x600@72 VGA pixel pipeline.
- During the horizontal blank of line n, it issues burst read requests for line n+1 into one half of an internal ping-pong line buffer. Line n is displayed from the other half.
- It presents the pixel for the current h_count/v_count to the colour path with fixed latency.
- It flags underflow when a line is not fully fetched by the time display of that line starts.

Parameters:
- H_PIXELS, 800, active pixels per line
- V_PIXELS, 600, active lines per frame
- H_PERIOD, 1040, total clocks per line (800+56+120+64)
- V_PERIOD, 666, total lines per frame (600+37+6+23)
- BURST_LEN, 32, max pixels per read request (1..255)
- ADDR_W, 32, byte address width; one pixel = one 32-bit word, 4 bytes, RGB in bits [23:0]

Ports:
- vga_clk  in  1  pixel clock
- rstn  in  1  async active-low reset
- h_count  in  12  horizontal counter from timing generator, 0..H_PERIOD-1
- v_count  in  12  vertical counter from timing generator, 0..V_PERIOD-1
- enable  in  1  fetch/display enable
- fb_base  in  ADDR_W  framebuffer byte base address
- rd_req_valid  out  1  read request valid
- rd_req_ready  in  1  memory port accepts request
- rd_req_addr  out  ADDR_W  request byte address
- rd_req_len  out  8  request length in pixels
- rd_data_valid  in  1  read beat valid, one pixel per beat, in order
- rd_data  in  24  read beat RGB
- pix_rgb  out  24  pixel colour
- pix_valid  out  1  pix_rgb is an active-area pixel
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  clears underflow
- busy  out  1  fetch FSM not IDLE

Behaviour:
- Reset:
  - Reset is rstn, asynchronous, active-low; the block is clocked on vga_clk.
  - While reset is asserted, all outputs are 0, the FSM is IDLE, and both bank-ready flags are cleared.
  - A reset mid-fetch discards the fetch. Beats arriving after reset is released are ignored.
- Triggers (sampled on the vga_clk edge, enable=1):
  - Line trigger: h_count==H_PIXELS and v_count<V_PIXELS-1 fetches line v_count+1.
  - Frame trigger: h_count==H_PIXELS and v_count==V_PERIOD-1 fetches line 0 and latches fb_base.
  - No other triggers exist.
- Bank selection:
  - Target bank = target line[0].
  - A trigger clears that bank's ready flag.
- Trigger while busy:
  - The trigger is dropped and its bank is left not-ready.
  - The in-flight fetch completes normally.
- Address:
  - addr = base_latched + (line*H_PIXELS + px_off)*4, modulo 2^ADDR_W.
  - px_off = pixels already requested for this line.
- Length:
  - len = min(BURST_LEN, H_PIXELS - px_off). With the defaults this gives 25 bursts of 32.
- FSM states: IDLE, REQ, DATA, DONE.
  - IDLE -> REQ on a trigger.
  - REQ: rd_req_valid=1, with addr/len held stable until rd_req_ready. On the handshake cycle go to DATA.
  - DATA: each rd_data_valid writes rd_data to bank[target][wr_ptr] and increments wr_ptr. Only one request is outstanding at a time.
    - After the len-th beat, go to REQ if wr_ptr<H_PIXELS, else go to DONE.
  - DONE: set the target bank-ready flag, then go to IDLE (1 cycle).
  - rd_data_valid outside DATA is ignored.
- Display (1-cycle latency):
  - Active area = h_count<H_PIXELS and v_count<V_PIXELS.
  - In the active area, with the bank for v_count[0] ready and enable=1: next cycle pix_rgb = bank[v_count[0]][h_count] and pix_valid=1.
  - Otherwise pix_rgb=0 and pix_valid=0.
- Underflow:
  - At h_count==0 of an active line, if that line's bank is not ready and enable=1, set underflow and show black for the whole line.
  - underflow_clr clears underflow. A simultaneous set and clear leaves it set.
- Bank-ready lifetime:
  - Line n's bank is not re-targeted until the line n+1 trigger, so it stays ready for the whole of line n.
- enable=0:
  - No new triggers are accepted and any in-progress fetch completes.
  - pix_valid=0 and pix_rgb=0.
- Line buffer: 2 x H_PIXELS x 24-bit, one write port and one read port, inferable as block RAM.

Test Plan:
- Frame trigger with rd_req_ready=1 and zero-latency data, fb_base=0x1000_0000 -> 25 requests for line 0:
  - first addr=0x1000_0000, len=32;
  - last addr=0x1000_0C00, len=32;
  - busy drops; line 0 displays the data with pix_valid 1 cycle after h_count.
- Line trigger at v_count=5, base 0 -> first addr=6*800*4=0x4B00; data lands in bank 0, line 5 continues to display from bank 1 unaffected.
- H_PIXELS=100, BURST_LEN=32 -> lengths 32,32,32,4; rd_req_addr and rd_req_len are held while rd_req_ready is low for 7 cycles.
- Memory stalls 300 cycles per burst -> the line trigger during busy is dropped; underflow=1 at the next line start and pix_rgb=0 across that line; underflow_clr -> 0.
- Reset asserted mid-DATA after 10 beats -> outputs 0 and FSM IDLE; stray beats after release are ignored; the next frame fetches correctly.
- fb_base changes mid-frame -> addresses use the old base until the next frame trigger.
